// File: rtl/hk_fetch_seq.sv
// hk_fetch_seq: loads the eight H words from the H/K constant memory into a
// parallel bank, then streams the 64 K round constants through a 2-entry skid buffer.
module hk_fetch_seq (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         start_i,
    input  logic         hk_rdy_i,
    input  logic [31:0]  hk_dr_i,
    output logic         hk_selector_o,
    output logic [2:0]   h_addr_o,
    output logic [5:0]   k_addr_o,
    output logic [255:0] h_out_o,
    output logic         h_vld_o,
    output logic [31:0]  k_out_o,
    output logic         k_vld_o,
    input  logic         k_rdy_i,
    output logic [5:0]   round_o,
    output logic         k_last_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_MEM = 3'd1,
        S_LOAD_H   = 3'd2,
        S_STREAM_K = 3'd3,
        S_FINISH   = 3'd4
    } state_e;

    state_e          state_q;
    logic            hk_sel_q;
    logic [2:0]      h_addr_q;
    logic [5:0]      k_addr_q;
    logic [255:0]    h_out_q;
    logic            h_vld_q;
    logic            busy_q;
    logic            done_q;
    logic [6:0]      issue_cnt_q;
    logic            inflight_q;
    logic [1:0]      occ_q;
    logic [1:0]      occ_d;
    logic [1:0][31:0] buf_data_q;
    logic [1:0][31:0] buf_data_d;
    logic [1:0][5:0]  buf_round_q;
    logic [1:0][5:0]  buf_round_d;
    logic            xfer_s;
    logic            last_xfer_s;
    logic            issue_s;
    logic [1:0]      occ_pop_s;

    // Skid buffer next state: pop the head on transfer, then append the word fetched last cycle.
    always_comb begin
        xfer_s      = (occ_q != 2'd0) && k_rdy_i;
        last_xfer_s = xfer_s && (buf_round_q[0] == 6'd63);
        occ_pop_s   = occ_q - {1'b0, xfer_s};
        // Occupancy plus the fetch in flight may never exceed the two buffer slots.
        issue_s     = (state_q == S_STREAM_K) && (issue_cnt_q < 7'd64) &&
                      (({1'b0, occ_pop_s} + {2'b00, inflight_q}) < 3'd2);
        buf_data_d  = buf_data_q;
        buf_round_d = buf_round_q;
        if (xfer_s) begin
            buf_data_d[0]  = buf_data_q[1];
            buf_round_d[0] = buf_round_q[1];
        end else begin
            buf_data_d[0]  = buf_data_q[0];
            buf_round_d[0] = buf_round_q[0];
        end
        if (inflight_q) begin
            buf_data_d[occ_pop_s[0]]  = hk_dr_i;
            buf_round_d[occ_pop_s[0]] = k_addr_q;
            occ_d = occ_pop_s + 2'd1;
        end else begin
            occ_d = occ_pop_s;
        end
    end

    // Sequencer state, memory addressing, H bank capture and buffer registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            hk_sel_q    <= 1'b0;
            h_addr_q    <= 3'd0;
            k_addr_q    <= 6'd0;
            h_out_q     <= 256'd0;
            h_vld_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            issue_cnt_q <= 7'd0;
            inflight_q  <= 1'b0;
            occ_q       <= 2'd0;
            buf_data_q  <= '0;
            buf_round_q <= '0;
        end else begin
            occ_q       <= occ_d;
            buf_data_q  <= buf_data_d;
            buf_round_q <= buf_round_d;
            done_q      <= 1'b0;
            inflight_q  <= issue_s;
            if (issue_s) begin
                k_addr_q    <= issue_cnt_q[5:0];
                issue_cnt_q <= issue_cnt_q + 7'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        h_vld_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (hk_rdy_i) begin
                            state_q  <= S_LOAD_H;
                            hk_sel_q <= 1'b0;
                            h_addr_q <= 3'd0;
                        end else begin
                            state_q  <= S_WAIT_MEM;
                        end
                    end
                end
                S_WAIT_MEM: begin
                    if (hk_rdy_i) begin
                        state_q  <= S_LOAD_H;
                        hk_sel_q <= 1'b0;
                        h_addr_q <= 3'd0;
                    end
                end
                S_LOAD_H: begin
                    // Read data belongs to the address driven during the cycle just ended.
                    h_out_q[{~h_addr_q, 5'd0} +: 32] <= hk_dr_i;
                    if (h_addr_q == 3'd7) begin
                        state_q     <= S_STREAM_K;
                        h_vld_q     <= 1'b1;
                        hk_sel_q    <= 1'b1;
                        k_addr_q    <= 6'd0;
                        issue_cnt_q <= 7'd1;
                        inflight_q  <= 1'b1;
                    end else begin
                        h_addr_q <= h_addr_q + 3'd1;
                    end
                end
                S_STREAM_K: begin
                    if (last_xfer_s) begin
                        state_q <= S_FINISH;
                        done_q  <= 1'b1;
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hk_selector_o = hk_sel_q;
    assign h_addr_o      = h_addr_q;
    assign k_addr_o      = k_addr_q;
    assign h_out_o       = h_out_q;
    assign h_vld_o       = h_vld_q;
    assign k_out_o       = buf_data_q[0];
    assign round_o       = buf_round_q[0];
    assign k_vld_o       = (occ_q != 2'd0);
    assign k_last_o      = (occ_q != 2'd0) && (buf_round_q[0] == 6'd63);
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: doc/hk_fetch_seq.md
# hk_fetch_seq

Sequencer directly downstream of the H/K constant memory. On each hash start it waits for the memory to report ready, then loads the eight initial H words into a parallel register bank. It then streams the 64 K round constants, in order, to the compression core through a valid/ready handshake with a 2-entry skid buffer. It is the only master of the H/K memory address and select inputs after initialisation.

## Interface
- No parameters. Widths are fixed at 32-bit words, 8 H words and 64 K words.
- CLK  in  1  single clock; all state changes on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle request to begin a hash block; sampled only in IDLE.
- HK_RDY  in  1  H/K memory initialisation complete.
- HK_DR  in  32  H/K memory read data; valid for the address driven during the previous cycle.
- HK_SELECTOR  out  1  0 = H bank, 1 = K bank; registered.
- H_ADDR  out  3  H word index; registered.
- K_ADDR  out  6  K word index; registered.
- H_OUT  out  256  H0 in [255:224] through H7 in [31:0].
- H_VLD  out  1  H_OUT is complete and stable.
- K_OUT  out  32  current round constant (head of skid buffer).
- K_VLD  out  1  K_OUT is valid.
- K_RDY  in  1  consumer accepts K_OUT; a transfer occurs on a posedge where K_VLD and K_RDY are both 1.
- ROUND  out  6  index of the word on K_OUT.
- K_LAST  out  1  K_VLD and ROUND == 63.
- BUSY  out  1  state is not IDLE.
- DONE  out  1  one-cycle pulse after K63 is transferred.

## Operation
- Reset values: state IDLE; HK_SELECTOR, H_ADDR, K_ADDR, H_OUT, H_VLD, K_VLD, ROUND, K_LAST, BUSY and DONE all 0; skid buffer empty; issue and return counters 0.
- States: IDLE, WAIT_MEM, LOAD_H, STREAM_K, FINISH.
- IDLE:
  - START=1 and HK_RDY=1 -> LOAD_H.
  - START=1 and HK_RDY=0 -> WAIT_MEM.
  - On START, H_VLD clears and H_OUT keeps its old value until overwritten.
- WAIT_MEM: -> LOAD_H on the first edge that samples HK_RDY=1.
- LOAD_H:
  - HK_SELECTOR=0; H_ADDR steps 0..7, one per cycle.
  - The word captured at each edge goes into the slot for the previous address.
  - After H7 is captured -> STREAM_K and H_VLD=1.
- STREAM_K:
  - HK_SELECTOR=1.
  - A new K address is issued only if (buffer occupancy + fetches in flight) < 2 after this edge's transfer.
  - K_ADDR increments per issue and stops after 63.
  - Returned data is pushed into the 2-entry FIFO; K_OUT, ROUND and K_LAST come from the head entry.
  - After the K63 transfer -> FINISH.
- FINISH: DONE=1 for exactly one cycle, then -> IDLE.
- H_OUT and H_VLD hold their values through FINISH and IDLE until the next START.
- START outside IDLE is ignored; a second START is never queued.
- HK_RDY falling outside IDLE and WAIT_MEM is not monitored. A mid-block re-init of the memory is the system's responsibility.
- RST_N low at any point aborts immediately to the reset values. There is no partial-state recovery.
- ROUND and K_ADDR are 6-bit and never wrap within a block; the counters stop at 63.

## Timing
- Edge T samples START with HK_RDY=1. H_ADDR=0 is driven after T.
- Edges T+1..T+8 capture H0..H7.
- At T+8: H_VLD=1, state=STREAM_K, K_ADDR=0.
- T+9: K0 enters the buffer, and K_VLD=1 after this edge.
- With K_RDY held at 1, K0..K63 transfer on edges T+10..T+73, one word per cycle with no bubbles.
- DONE is high during the cycle after T+73. BUSY drops at T+74.
- Backpressure: with K_RDY=0 the buffer fills to 2 and issuing stops. K_OUT and ROUND must be held stable while K_VLD=1 and K_RDY=0.
- Each WAIT_MEM cycle adds one cycle to every later timestamp.
- Minimum START-to-START spacing is 75 cycles.

## Test plan
- Reset, preload memory, HK_RDY=1, pulse START, hold K_RDY=1. Required:
  - H_OUT = 6a09e667_bb67ae85_…_5be0cd19 at T+8.
  - K_OUT = 428a2f98 at ROUND 0 and c67178f2 at ROUND 63 with K_LAST.
  - DONE at T+74, with exactly 64 transfers.
- START with HK_RDY=0 for 20 cycles: BUSY=1 and no address change. Raise HK_RDY: the schedule resumes with all timestamps shifted by 20 cycles.
- Toggle K_RDY randomly (50 %). Required:
  - 64 transfers in order, with no duplicates or gaps.
  - K_OUT stable across every stall.
  - Buffer never exceeds 2.
- Hold K_RDY=0 for 10 cycles after K_VLD rises. Required: K_OUT=428a2f98 held, K_ADDR stops at 1, and on release K0 and K1 transfer on consecutive edges.
- Extra START pulses during LOAD_H and STREAM_K: ignored, and a single DONE.
- Assert RST_N low at ROUND 30: all outputs return to 0 asynchronously. A fresh START then reproduces scenario 1 exactly.
